// File: rtl/jpeg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module  : jpeg_bitstream_packer
// Purpose : Packs up to LANES variable-length codes per input beat into an
//           MSB-first byte stream. Lane 0 goes first. The packer can insert a
//           0x00 after each emitted 0xFF (JPEG byte stuffing). On flush it
//           pads the last partial byte with 1s.
// Ports   : clk, srst        - clock, synchronous active-high reset
//           in_valid/in_ready - input beat handshake
//           in_len, in_code   - per-lane length (0 = absent) and right-aligned code
//           stuff_en          - 0xFF -> 0xFF,0x00 stuffing enable
//           flush/flush_done  - pad-and-drain request / completion pulse
//           out_valid/out_ready/out_data - output byte handshake
//           byte_count        - bytes transferred on the output, wraps
// Revision: 1.0 - initial release
// ============================================================================
module jpeg_bitstream_packer #(
  parameter int LANES   = 10,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*LEN_W-1:0]   in_len,
  input  logic [LANES*MAX_LEN-1:0] in_code,
  input  logic                     stuff_en,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [31:0]              byte_count
);

  // The accumulator holds fewer than 8 leftover bits plus one whole code.
  localparam int ACC_W  = MAX_LEN + 8;
  localparam int CNT_W  = $clog2(ACC_W);
  localparam int LIDX_W = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     pend_q, pend_d;
  logic [LIDX_W-1:0]        lane_q, lane_d;
  logic [LANES*LEN_W-1:0]   len_q, len_d;
  logic [LANES*MAX_LEN-1:0] code_q, code_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_data_q, out_data_d;
  logic [31:0]              byte_count_q, byte_count_d;

  logic                     w_slot_free;
  logic                     w_xfer;
  logic                     w_lanes_rem;
  logic                     w_cnt_ge8;
  logic                     w_cnt_zero;
  logic                     w_busy;
  logic                     w_act_stuff;
  logic                     w_act_emit;
  logic                     w_act_append;
  logic                     w_act_pad;
  logic [LIDX_W-1:0]        w_lane_sel;
  logic [LEN_W-1:0]         w_lane_len_raw;
  logic [LEN_W-1:0]         w_lane_len_clamp;
  logic [MAX_LEN-1:0]       w_lane_code_raw;
  logic [CNT_W-1:0]         w_app_len;
  logic [ACC_W-1:0]         w_app_bits;
  logic [CNT_W-1:0]         w_pad_len;
  logic [7:0]               w_emit_byte;
  logic                     w_in_ready;
  logic                     w_flush_done;

  // --------------------------------------------------------------------------
  // Action decode. The conditions are mutually exclusive, so exactly one
  // action (or a stall) happens each cycle, in priority order: stuff, emit,
  // then append or pad.
  // --------------------------------------------------------------------------
  assign w_slot_free = !out_valid_q || out_ready;
  assign w_xfer      = out_valid_q && out_ready;
  assign w_lanes_rem = lane_q < LIDX_W'(LANES);
  assign w_cnt_ge8   = cnt_q >= CNT_W'(8);
  assign w_cnt_zero  = cnt_q == '0;
  assign w_busy      = (state_q == S_MERGE) || (state_q == S_FLUSH);

  assign w_act_stuff  = w_busy && pend_q && w_slot_free;
  assign w_act_emit   = w_busy && !pend_q && w_cnt_ge8 && w_slot_free;
  assign w_act_append = (state_q == S_MERGE) && !pend_q && !w_cnt_ge8 && w_lanes_rem;
  assign w_act_pad    = (state_q == S_FLUSH) && !pend_q && !w_cnt_ge8 && !w_cnt_zero;

  // Keep the lane select in range after the last lane has been consumed.
  assign w_lane_sel       = w_lanes_rem ? lane_q : '0;
  assign w_lane_len_raw   = len_q[w_lane_sel*LEN_W +: LEN_W];
  assign w_lane_code_raw  = code_q[w_lane_sel*MAX_LEN +: MAX_LEN];
  assign w_lane_len_clamp = (w_lane_len_raw > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_lane_len_raw;
  assign w_app_len        = CNT_W'(w_lane_len_clamp);
  // Drop code bits above the effective length.
  assign w_app_bits       = ACC_W'(w_lane_code_raw) & ~({ACC_W{1'b1}} << w_app_len);

  assign w_pad_len   = CNT_W'(8) - cnt_q;
  // The oldest byte sits at acc[cnt-1 -: 8].
  assign w_emit_byte = 8'(acc_q >> (cnt_q - CNT_W'(8)));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_MERGE;
        end else if (flush) begin
          state_d = S_FLUSH;
        end
      end
      S_MERGE: begin
        if (!w_lanes_rem && !w_cnt_ge8 && !pend_q) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (w_cnt_zero && !pend_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!out_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. flush_done is combinational, so the requester sees it in
  // the same cycle the FSM leaves DONE. It can then drop flush before IDLE
  // samples it again.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready   = 1'b0;
    w_flush_done = 1'b0;
    case (state_q)
      S_IDLE:  w_in_ready   = 1'b1;
      S_DONE:  w_flush_done = !out_valid_q;
      default: begin
        w_in_ready   = 1'b0;
        w_flush_done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    lane_d       = lane_q;
    len_d        = len_q;
    code_d       = code_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    byte_count_d = byte_count_q + {31'd0, w_xfer};

    if (w_xfer) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == S_IDLE) && in_valid) begin
      len_d  = in_len;
      code_d = in_code;
      lane_d = '0;
    end

    if (w_act_stuff) begin
      out_valid_d = 1'b1;
      out_data_d  = 8'h00;
      pend_d      = 1'b0;
    end

    if (w_act_emit) begin
      out_valid_d = 1'b1;
      out_data_d  = w_emit_byte;
      cnt_d       = cnt_q - CNT_W'(8);
      pend_d      = stuff_en && (w_emit_byte == 8'hFF);
    end

    if (w_act_append) begin
      acc_d  = (acc_q << w_app_len) | w_app_bits;
      cnt_d  = cnt_q + w_app_len;
      lane_d = lane_q + LIDX_W'(1);
    end

    if (w_act_pad) begin
      acc_d = (acc_q << w_pad_len) | ~({ACC_W{1'b1}} << w_pad_len);
      cnt_d = CNT_W'(8);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      lane_q       <= '0;
      len_q        <= '0;
      code_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      byte_count_q <= 32'd0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      lane_q       <= lane_d;
      len_q        <= len_d;
      code_q       <= code_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign in_ready   = w_in_ready;
  assign flush_done = w_flush_done;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign byte_count = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bitstream_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_jpeg_bitstream_packer
// Purpose : Self-checking bench for jpeg_bitstream_packer. A scoreboard
//           queue holds the expected bytes. A monitor collects the
//           transferred bytes. Each test task compares the two.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jpeg_bitstream_packer;

  localparam int LANES   = 10;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic                     clk = 1'b0;
  logic                     srst;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*LEN_W-1:0]   in_len;
  logic [LANES*MAX_LEN-1:0] in_code;
  logic                     stuff_en;
  logic                     flush;
  logic                     flush_done;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_ready;
  logic [31:0]              byte_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_rd = 0;
  int         exp_total = 0;

  always #5 clk = ~clk;

  jpeg_bitstream_packer #(
    .LANES  (LANES),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_len    (in_len),
    .in_code   (in_code),
    .stuff_en  (stuff_en),
    .flush     (flush),
    .flush_done(flush_done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .byte_count(byte_count)
  );

  // Sink monitor: records every byte that completes a handshake.
  always @(negedge clk) begin
    if (!srst && out_valid && out_ready) obs_q.push_back(out_data);
  end

  // ---------------------------------------------------------------- helpers
  task automatic clear_lanes();
    in_len  = '0;
    in_code = '0;
  endtask

  task automatic set_lane(input int k, input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] code);
    in_len[k*LEN_W +: LEN_W]    = len;
    in_code[k*MAX_LEN +: MAX_LEN] = code;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
    exp_total++;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    exp_q.delete();
    obs_rd    = obs_q.size();
    exp_total = 0;
  endtask

  // Presents the lanes currently on in_len/in_code until accepted.
  task automatic send_beat(output bit ok);
    bit acc;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    in_valid = 1'b0;
  endtask

  // Holds flush until the completion pulse shows up.
  task automatic run_flush(output bit ok);
    ok = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (flush_done) ok = 1'b1;
    end
    flush = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (in_ready && !out_valid && (obs_q.size() - obs_rd >= exp_q.size())) ok = 1'b1;
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_cmp++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done: got %b, required 0", flush_done); end
    n_cmp++; if (byte_count !== 32'd0) begin n_err++; $display("FAIL reset_byte_count: got %0d, required 0", byte_count); end
  endtask

  task automatic test_two_lanes(input string tag);
    bit ok;
    logic [7:0] e, o;
    clear_lanes();
    set_lane(0, 6'd3, 32'b101);
    set_lane(1, 6'd5, 32'b10011);
    push_exp(8'hB3);
    send_beat(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_accept: got no accept, required accept", tag); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_idle: got timeout, required idle", tag); end
    run_flush(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL %s_flush_done: got no pulse, required pulse", tag); end
    @(posedge clk); #1;
    n_cmp++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_pulse_width: got done=%b ready=%b, required done=0 ready=1", tag, flush_done, in_ready);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_err++; $display("FAIL %s_byte: got none, required %h", tag, e); end
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) begin n_err++; $display("FAIL %s_byte: got %h, required %h", tag, o, e); end
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL %s_extra: got %0d extra bytes, required 0", tag, obs_q.size() - obs_rd); end
    n_cmp++; if (byte_count !== 32'(exp_total)) begin n_err++; $display("FAIL %s_count: got %0d, required %0d", tag, byte_count, exp_total); end
  endtask

  task automatic test_pad_flush();
    bit ok;
    logic [7:0] e, o;
    do_reset();
    clear_lanes();
    set_lane(0, 6'd4, 32'b0101);
    push_exp(8'h5F);
    send_beat(ok);
    wait_idle(ok);
    run_flush(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pad_flush_done: got no pulse, required pulse"); end
    wait_idle(ok);
    // An empty flush must complete without producing a byte.
    run_flush(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pad_empty_flush_done: got no pulse, required pulse"); end
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_err++; $display("FAIL pad_byte: got none, required %h", e); end
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) begin n_err++; $display("FAIL pad_byte: got %h, required %h", o, e); end
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL pad_extra: got %0d extra bytes, required 0", obs_q.size() - obs_rd); end
    n_cmp++; if (byte_count !== 32'd1) begin n_err++; $display("FAIL pad_count: got %0d, required 1", byte_count); end
  endtask

  task automatic test_stuffing(input bit en);
    bit ok;
    logic [7:0] e, o;
    do_reset();
    stuff_en = en;
    clear_lanes();
    set_lane(0, 6'd8, 32'hFF);
    push_exp(8'hFF);
    if (en) push_exp(8'h00);
    send_beat(ok);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stuff%0d_idle: got timeout, required idle", en); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_err++; $display("FAIL stuff%0d_byte: got none, required %h", en, e); end
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) begin n_err++; $display("FAIL stuff%0d_byte: got %h, required %h", en, o, e); end
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL stuff%0d_extra: got %0d extra bytes, required 0", en, obs_q.size() - obs_rd); end
    n_cmp++; if (byte_count !== 32'(exp_total)) begin n_err++; $display("FAIL stuff%0d_count: got %0d, required %0d", en, byte_count, exp_total); end
    stuff_en = 1'b0;
  endtask

  task automatic load_full_beat();
    clear_lanes();
    for (int k = 0; k < LANES; k++) set_lane(k, 6'd32, 32'hA5A5A5A5);
  endtask

  task automatic test_back_to_back();
    bit ok, fin, stalled, seen_ready;
    logic [7:0] held, e, o;
    do_reset();
    load_full_beat();
    for (int i = 0; i < 4 * LANES; i++) push_exp(8'hA5);
    send_beat(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_accept: got no accept, required accept"); end
    fin = 1'b0; stalled = 1'b0; seen_ready = 1'b0; held = 8'h00;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_err++; $display("FAIL b2b_stable: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      @(posedge clk);
      #1;
      if (in_ready && !seen_ready) begin
        seen_ready = 1'b1;
        n_cmp++;
        if (obs_q.size() - obs_rd < 4 * LANES - 1) begin
          n_err++; $display("FAIL b2b_in_ready: got ready after %0d bytes, required >= %0d", obs_q.size() - obs_rd, 4 * LANES - 1);
        end
      end
      if (in_ready && !out_valid) fin = 1'b1;
      else out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    n_cmp++; if (!fin) begin n_err++; $display("FAIL b2b_idle: got timeout, required idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_err++; $display("FAIL b2b_byte: got none, required %h", e); end
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) begin n_err++; $display("FAIL b2b_byte: got %h, required %h", o, e); end
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL b2b_extra: got %0d extra bytes, required 0", obs_q.size() - obs_rd); end
    n_cmp++; if (byte_count !== 32'd40) begin n_err++; $display("FAIL b2b_count: got %0d, required 40", byte_count); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    load_full_beat();
    send_beat(ok);
    repeat (2) @(posedge clk);
    #1 srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
    n_cmp++; if (byte_count !== 32'd0) begin n_err++; $display("FAIL midrst_count: got %0d, required 0", byte_count); end
    exp_q.delete();
    obs_rd    = obs_q.size();
    exp_total = 0;
    test_two_lanes("midrst_rerun");
  endtask

  task automatic test_clamp();
    bit ok;
    logic [7:0] e, o;
    do_reset();
    clear_lanes();
    set_lane(0, 6'd4, 32'hFFFFFFF0);
    push_exp(8'h0F);
    send_beat(ok);
    wait_idle(ok);
    run_flush(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL clamp_flush_done: got no pulse, required pulse"); end
    clear_lanes();
    set_lane(0, 6'd40, 32'h12345678);
    set_lane(1, 6'd8, 32'hFFFFFF9A);
    push_exp(8'h12); push_exp(8'h34); push_exp(8'h56); push_exp(8'h78); push_exp(8'h9A);
    send_beat(ok);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL clamp_idle: got timeout, required idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin n_err++; $display("FAIL clamp_byte: got none, required %h", e); end
      else begin
        o = obs_q[obs_rd]; obs_rd++;
        if (o !== e) begin n_err++; $display("FAIL clamp_byte: got %h, required %h", o, e); end
      end
    end
    n_cmp++; if (obs_q.size() != obs_rd) begin n_err++; $display("FAIL clamp_extra: got %0d extra bytes, required 0", obs_q.size() - obs_rd); end
    n_cmp++; if (byte_count !== 32'(exp_total)) begin n_err++; $display("FAIL clamp_count: got %0d, required %0d", byte_count, exp_total); end
  endtask

  initial begin
    srst      = 1'b1;
    in_valid  = 1'b0;
    stuff_en  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_len    = '0;
    in_code   = '0;
    test_reset();
    test_two_lanes("two_lanes");
    test_pad_flush();
    test_stuffing(1'b1);
    test_stuffing(1'b0);
    test_back_to_back();
    test_mid_reset();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
